// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// result-source codes, controller FSM states and performance-counter helpers.
package hazard_ctrl_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_ABORT    = 2'd2
    } state_t;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic             en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one EX source register; MEM beats WB because
// it carries the younger write to the same register.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwd = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stalls, redirect flushes and
// a multi-cycle MDU handshake with a watchdog that aborts a hung operation.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic [1:0]       ex_result_src,
    input  logic             ex_pc_src,
    input  logic             ex_mdu_op,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             mdu_done,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mdu_go,
    output logic             mdu_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int              WD_W    = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              mdu_err_q, mdu_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic       stall_f_c, stall_d_c, stall_e_c;
    logic       flush_d_c, flush_e_c, flush_m_c, mdu_go_c;
    logic [1:0] fwd_a_c, fwd_b_c;
    logic       load_use;

    fwd_sel u_fwd_a (
        .ex_rs        (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_a_c)
    );

    fwd_sel u_fwd_b (
        .ex_rs        (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_b_c)
    );

    assign load_use = (ex_result_src == RES_LOAD) && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Priority in RUN: MDU start, then redirect, then load-use stall.
    always_comb begin
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        stall_e_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        flush_m_c = 1'b0;
        mdu_go_c  = 1'b0;
        state_d   = state_q;
        wdog_d    = wdog_q;
        mdu_err_d = mdu_err_q;
        unique case (state_q)
            ST_RUN: begin
                if (ex_mdu_op) begin
                    mdu_go_c  = 1'b1;
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                    wdog_d    = '0;
                    state_d   = ST_MDU_WAIT;
                end else if (ex_pc_src) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (load_use) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                if (mdu_done) begin
                    wdog_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                    if (wdog_q == WD_LAST) begin
                        wdog_d    = '0;
                        mdu_err_d = 1'b1;
                        state_d   = ST_ABORT;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                flush_e_c = 1'b1;
                state_d   = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Every combinational output is forced quiet while reset is held low.
    assign stall_f = reset & stall_f_c;
    assign stall_d = reset & stall_d_c;
    assign stall_e = reset & stall_e_c;
    assign flush_d = reset & flush_d_c;
    assign flush_e = reset & flush_e_c;
    assign flush_m = reset & flush_m_c;
    assign mdu_go  = reset & mdu_go_c;
    assign fwd_a   = reset ? fwd_a_c : FWD_RF;
    assign fwd_b   = reset ? fwd_b_c : FWD_RF;

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, stall_f);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wdog_q      <= '0;
            mdu_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            mdu_err_q   <= mdu_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mdu_err   = mdu_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, redirect, MDU handshake,
// watchdog abort and asynchronous reset behaviour.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic [1:0]  ex_result_src;
    logic        ex_pc_src, ex_mdu_op, mem_regwrite, wb_regwrite, mdu_done;
    logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic [1:0]  fwd_a, fwd_b;
    logic        mdu_go, mdu_err;
    logic [15:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.MDU_TIMEOUT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_result_src (ex_result_src),
        .ex_pc_src     (ex_pc_src),
        .ex_mdu_op     (ex_mdu_op),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .mem_regwrite  (mem_regwrite),
        .wb_regwrite   (wb_regwrite),
        .mdu_done      (mdu_done),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .stall_e       (stall_e),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .flush_m       (flush_m),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .mdu_go        (mdu_go),
        .mdu_err       (mdu_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
        mem_rd = 5'd0; wb_rd = 5'd0; ex_result_src = 2'b00; ex_pc_src = 1'b0;
        ex_mdu_op = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic set_load_use();
        ex_result_src = 2'b01; ex_rd = 5'd5; id_rs2 = 5'd5;
    endtask

    initial begin
        // Reset held low: hazards present on the inputs must not reach outputs.
        reset = 1'b0;
        clr();
        set_load_use();
        mem_rd = 5'd7; ex_rs1 = 5'd7; mem_regwrite = 1'b1;
        #2;
        chk("rst_stall_f", stall_f, 1'b0);
        chk("rst_flush_e", flush_e, 1'b0);
        chk("rst_fwd_a", fwd_a, 2'b00);
        chk("rst_mdu_go", mdu_go, 1'b0);
        chk("rst_mdu_err", mdu_err, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 16'd0);
        chk("rst_flush_cnt", flush_cnt, 16'd0);
        tick();
        clr();
        reset = 1'b1;
        tick();

        // Load-use on rs2.
        set_load_use();
        #1;
        chk("lu_stall_f", stall_f, 1'b1);
        chk("lu_stall_d", stall_d, 1'b1);
        chk("lu_flush_e", flush_e, 1'b1);
        chk("lu_stall_e", stall_e, 1'b0);
        chk("lu_flush_d", flush_d, 1'b0);
        tick();
        clr();
        #1;
        chk("lu_release", stall_f, 1'b0);
        chk("lu_stall_cnt", stall_cnt, 16'd1);

        // Forwarding: MEM beats WB, x0 never forwards, WB alone selects 01.
        mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #1;
        chk("fwd_both", fwd_a, 2'b10);
        chk("fwd_b_none", fwd_b, 2'b00);
        ex_rs1 = 5'd0;
        #1;
        chk("fwd_x0", fwd_a, 2'b00);
        ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_regwrite = 1'b0;
        #1;
        chk("fwd_a_wb", fwd_a, 2'b01);
        chk("fwd_b_wb", fwd_b, 2'b01);
        clr();

        // Redirect coinciding with a load-use hazard.
        set_load_use();
        ex_pc_src = 1'b1;
        #1;
        chk("rd_flush_d", flush_d, 1'b1);
        chk("rd_flush_e", flush_e, 1'b1);
        chk("rd_stall_f", stall_f, 1'b0);
        chk("rd_stall_d", stall_d, 1'b0);
        tick();
        clr();
        #1;
        chk("rd_flush_cnt", flush_cnt, 16'd1);
        chk("rd_stall_cnt", stall_cnt, 16'd1);

        // mdu_done in RUN has no effect.
        mdu_done = 1'b1;
        #1;
        chk("run_done_stall_e", stall_e, 1'b0);
        chk("run_done_flush_e", flush_e, 1'b0);
        tick();
        clr();

        // MDU op completing on the fifth cycle after issue.
        ex_mdu_op = 1'b1;
        #1;
        chk("mdu_go_issue", mdu_go, 1'b1);
        chk("mdu_stall_e0", stall_e, 1'b1);
        chk("mdu_flush_m0", flush_m, 1'b1);
        tick();
        for (int i = 1; i <= 4; i++) begin
            ex_pc_src = (i == 2);
            #1;
            chk($sformatf("mdu_wait_go%0d", i), mdu_go, 1'b0);
            chk($sformatf("mdu_wait_stall_e%0d", i), stall_e, 1'b1);
            chk($sformatf("mdu_wait_flush_d%0d", i), flush_d, 1'b0);
            tick();
        end
        ex_pc_src = 1'b0;
        mdu_done = 1'b1;
        #1;
        chk("mdu_done_stall_e", stall_e, 1'b0);
        chk("mdu_done_stall_f", stall_f, 1'b0);
        chk("mdu_done_flush_m", flush_m, 1'b0);
        chk("mdu_done_go", mdu_go, 1'b0);
        tick();
        clr();
        ex_pc_src = 1'b1;
        #1;
        chk("mdu_back_run", flush_d, 1'b1);
        chk("mdu_stall_cnt", stall_cnt, 16'd6);
        tick();
        clr();
        #1;
        chk("mdu_flush_cnt", flush_cnt, 16'd2);

        // Watchdog timeout: eight MDU_WAIT cycles then a single ABORT cycle.
        ex_mdu_op = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("to_wait_stall_e%0d", i), stall_e, 1'b1);
            tick();
        end
        #1;
        chk("abort_flush_e", flush_e, 1'b1);
        chk("abort_stall_f", stall_f, 1'b0);
        chk("abort_stall_e", stall_e, 1'b0);
        chk("abort_go", mdu_go, 1'b0);
        chk("abort_err", mdu_err, 1'b1);
        chk("abort_stall_cnt", stall_cnt, 16'd15);
        tick();
        clr();
        #1;
        chk("post_abort_flush_e", flush_e, 1'b0);
        chk("post_abort_err", mdu_err, 1'b1);
        tick();
        chk("err_sticky", mdu_err, 1'b1);

        // Reset pulled mid-MDU_WAIT abandons the op without flagging an error.
        ex_mdu_op = 1'b1;
        tick();
        tick();
        mem_rd = 5'd3; ex_rs2 = 5'd3; mem_regwrite = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_stall_f", stall_f, 1'b0);
        chk("mid_rst_stall_e", stall_e, 1'b0);
        chk("mid_rst_flush_m", flush_m, 1'b0);
        chk("mid_rst_go", mdu_go, 1'b0);
        chk("mid_rst_fwd_b", fwd_b, 2'b00);
        chk("mid_rst_err", mdu_err, 1'b0);
        chk("mid_rst_stall_cnt", stall_cnt, 16'd0);
        tick();
        clr();
        reset = 1'b1;
        ex_pc_src = 1'b1;
        #1;
        chk("mid_rst_run", flush_d, 1'b1);
        chk("mid_rst_err_after", mdu_err, 1'b0);
        tick();
        clr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
